arb_req_client: RTL
===================

Name: arb_req_client

Overview:
- Requester-side agent that drives one `req` line of the 4-way grant arbiter and consumes the matching `gnt` bit.
- Queues local jobs, each a burst of 1..2^LEN_W beats, in a small FIFO.
- For each job: raises `req`, counts granted beats, releases `req`.
- Tolerates the arbiter's 1-cycle registered grant latency, preemption (forced grants elsewhere, access-off), and unsolicited grants (forced/access-on). Flags starvation and unsolicited grants.

Parameters:
- DEPTH, 4, job FIFO entries (power of 2, ≥2)
- LEN_W, 4, job length field width; beats per job = job_len+1
- WAIT_W, 4, stall counter width
- TIMEOUT, 8, stall cycles at which `starve` asserts; 1 ≤ TIMEOUT ≤ 2^WAIT_W-1

Ports:
- clk, in, 1, clock
- rst, in, 1, reset
- job_valid, in, 1, job offered
- job_len, in, LEN_W, beats-1 of offered job
- job_ready, out, 1, FIFO can accept
- req, out, 1, request to arbiter
- gnt, in, 1, grant bit from arbiter (registered there, 1-cycle after req)
- beat, out, 1, one granted transfer cycle this cycle
- done, out, 1, 1-cycle pulse: job completed
- busy, out, 1, job active (state REQ)
- pending, out, $clog2(DEPTH)+1, FIFO occupancy
- wait_cnt, out, WAIT_W, consecutive stalled cycles in REQ
- starve, out, 1, wait_cnt ≥ TIMEOUT
- unsolicited, out, 1, sticky: grant with no explaining request
- clr_err, in, 1, clears unsolicited

Behaviour:
- Reset: rst is asynchronous and active-high; the clock is clk.
  - All outputs are 0 during and after reset, except `job_ready`=1.
  - FIFO flushed, state IDLE, active job discarded.
  - `done` is not pulsed for an aborted job.
- FIFO:
  - `job_ready` = !full.
  - Push on job_valid && job_ready; no bypass.
  - Push and pop in the same cycle are both legal (occupancy unchanged).
- FSM, 2 states, registered:
  - IDLE: req=0. If FIFO non-empty, pop head, beats_left ← job_len+1, go to REQ.
  - REQ: req=1, busy=1.
    - beat = gnt (combinational, same cycle).
    - Each beat decrements beats_left.
    - On the beat with beats_left==1: go to IDLE; `done`=1 in the next cycle (registered).
- Latency:
  - Push at cycle 0 → pop cycle 1 → req=1 cycle 2 → earliest beat cycle 3.
- Back-to-back jobs:
  - req is low for exactly 1 cycle between jobs (the IDLE cycle), which lets the arbiter rotate.
  - The next job pops in that cycle.
- Preemption:
  - gnt=0 while in REQ → no beat; hold req=1 and keep beats_left.
  - Resume counting when gnt returns.
  - No limit on preemption length.
- Stall counter:
  - In REQ with gnt=0: wait_cnt increments, saturating at 2^WAIT_W-1.
  - Cleared on any beat and in IDLE.
  - The cycle req first rises (before the grant can arrive) counts as a stall.
  - `starve` is combinational from wait_cnt.
- Unsolicited grant:
  - Set when gnt=1 && req=0 && req_prev=0, where req_prev is req registered one cycle.
  - The trailing grant the cycle after req falls is expected and does not flag.
  - Sticky until clr_err=1.
  - Set and clear in the same cycle → set wins.
  - Unsolicited grants never produce a beat.
- Width rules:
  - beats_left is LEN_W+1 bits.
  - job_len = 2^LEN_W-1 gives 2^LEN_W beats without overflow.

Test Plan:
- Single job, arbiter model gnt(t)=req(t-1): push job_len=2 at cycle 0 → req=1 cycles 2-5; beats cycles 3,4,5; req=0 and done=1 at cycle 6; gnt=1 at cycle 6 does not set unsolicited.
- Preemption, TIMEOUT=8: job_len=3; force gnt=0 for 10 cycles after beat 2 → req stays 1; wait_cnt reaches 8 and starve=1 on the 8th stall cycle; wait_cnt saturates/holds counting to 10; on grant return, beats 3,4 occur, then done; starve=0 at first resumed beat.
- Unsolicited: idle, drive gnt=1 for 2 cycles → unsolicited=1 from the first such cycle, no beat; hold through clr_err=0; clr_err=1 → unsolicited=0 next cycle; clr_err with concurrent unsolicited grant → stays 1.
- FIFO full, DEPTH=4, gnt=0: push 6 jobs back-to-back from cycle 0 → jobs 1-5 accepted (job 1 popped cycle 1); job_ready=0 at cycle 5; pending=4.
- Back-to-back: two queued jobs job_len=0 with grant model → req pattern 1,1,0,1,1; one done per job; exactly 1 low req cycle between jobs.
- Reset mid-job: rst during beat 2 of a 4-beat job with 2 queued → req=0, busy=0, pending=0, no done; after release, push job_len=0 → normal 1-beat completion.

Source files
------------

// File: rtl/arb_req_client.sv
// Requester-side agent for one port of the 4-way grant arbiter: queues burst
// jobs, requests the arbiter per job, counts granted beats and flags anomalies.
module arb_req_client #(
  parameter int DEPTH   = 4,
  parameter int LEN_W   = 4,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  input  logic [LEN_W-1:0]         job_len,
  output logic                     job_ready,
  output logic                     req,
  input  logic                     gnt,
  output logic                     beat,
  output logic                     done,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending,
  output logic [WAIT_W-1:0]        wait_cnt,
  output logic                     starve,
  output logic                     unsolicited,
  input  logic                     clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               push, pop, full, empty;
  logic [LEN_W:0]     beats_left, beats_nxt;
  logic [WAIT_W-1:0]  stall_q, stall_nxt;
  logic               req_prev, unsol_q, unsol_set, done_q, last_beat;

  // Job handshake: a job transfers on every clock edge where job_valid and
  // job_ready are both high; job_ready depends only on FIFO occupancy.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign job_ready = !full;
  assign push      = job_valid && !full;
  assign pending   = count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= job_len;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    beats_nxt = beats_left;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          beats_nxt = {1'b0, mem[rd_ptr]} + (LEN_W+1)'(1);
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (gnt) begin
          beats_nxt = beats_left - (LEN_W+1)'(1);
          if (beats_left == (LEN_W+1)'(1)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign req       = (state == REQ);
  assign busy      = req;
  assign beat      = req && gnt;
  assign last_beat = beat && (beats_left == (LEN_W+1)'(1));
  assign done      = done_q;

  // Stall count includes the current cycle, so a beat clears it immediately.
  always_comb begin
    stall_nxt = '0;
    if (req && !gnt) begin
      stall_nxt = (stall_q == {WAIT_W{1'b1}}) ? stall_q : stall_q + 1'b1;
    end
  end

  assign wait_cnt = stall_nxt;
  assign starve   = (wait_cnt >= WAIT_W'(TIMEOUT));

  // A grant the cycle after req falls is the arbiter's registered tail.
  assign unsol_set   = gnt && !req && !req_prev && !rst;
  assign unsolicited = unsol_q || unsol_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      beats_left <= '0;
      stall_q    <= '0;
      req_prev   <= 1'b0;
      unsol_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      beats_left <= beats_nxt;
      stall_q    <= stall_nxt;
      req_prev   <= req;
      unsol_q    <= unsol_set || (unsol_q && !clr_err);
      done_q     <= last_beat;
    end
  end

endmodule
